// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Purpose  : Reset/lock sequencer for the 16->32 MHz SB_PLL40_CORE wrapper.
//            Runs on the 16 MHz reference clock. It pulses the PLL's RESETB
//            low, waits for a stable LOCK, then releases the fabric reset.
//            A lock timeout or a loss of lock retries the PLL and bumps a
//            saturating retry counter.
// Ports    : clk_i          16 MHz reference clock (same net as REFERENCECLK)
//            rst_ni         asynchronous active-low reset
//            pll_lock_i     PLL LOCK, asynchronous to clk_i
//            req_reset_i    synchronous request to re-reset the PLL
//            pll_resetb_o   to PLL RESETB (active low)
//            sys_reset_n_o  active-low fabric reset; 32 MHz consumers must
//                           re-synchronise it with two flops
//            locked_o       high while in RUN
//            retry_count_o  saturating count of timeout / lock-loss retries
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 16384,
  parameter int STABLE_CYCLES  = 256,
  parameter int RETRY_W        = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pll_lock_i,
  input  logic               req_reset_i,
  output logic               pll_resetb_o,
  output logic               sys_reset_n_o,
  output logic               locked_o,
  output logic [RETRY_W-1:0] retry_count_o
);

  // One shared counter, wide enough for the largest terminal count.
  localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int CNT_W  = (MAX_P > 2) ? $clog2(MAX_P) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               retry_inc;
  logic               lock_meta_q, lock_s_q;
  logic               pll_resetb_q, run_q;

  // Next-state logic. REQ_RESET is evaluated first so it overrides every
  // lock, timeout and stability event in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_inc = 1'b0;
    if (req_reset_i) begin
      state_d = S_PLL_RST;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TMO_LAST) begin
            state_d   = S_PLL_RST;
            cnt_d     = '0;
            retry_inc = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STABLE: begin
          // Any dropout restarts the lock wait with a fresh timeout; it is
          // not a retry because the PLL is not reset.
          if (!lock_s_q) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lock_s_q) begin
            state_d   = S_PLL_RST;
            cnt_d     = '0;
            retry_inc = 1'b1;
          end
        end
        default: begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Saturating retry counter: never wraps back to zero.
  always_comb begin
    retry_d = retry_q;
    if (retry_inc && (retry_q != {RETRY_W{1'b1}})) begin
      retry_d = retry_q + RETRY_W'(1);
    end
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      pll_resetb_q <= 1'b0;
      run_q        <= 1'b0;
    end else begin
      lock_meta_q  <= pll_lock_i;
      lock_s_q     <= lock_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_resetb_q <= (state_d != S_PLL_RST);
      run_q        <= (state_d == S_RUN);
    end
  end

  assign pll_resetb_o  = pll_resetb_q;
  assign sys_reset_n_o = run_q;
  assign locked_o      = run_q;
  assign retry_count_o = retry_q;

endmodule
`default_nettype wire
